imem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port synchronous instruction/data memory between the processor's instruction-fetch port and its load/store port. It sits between the processor and the memory array. It grants at most one access per cycle and routes read data back to the requester that issued the read, one cycle later. It also bounds-checks addresses against the populated memory depth.

---
 rtl/imem_arbiter.sv | 121 ++++++++++++
 tb/tb_imem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-requester arbiter (instruction fetch vs load/store) in front of a single-port synchronous memory.
// Optional build macro IMEM_ARB_LS_PRIORITY_EN: LS wins every tie instead of round-robin.
module imem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 41
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    IF_LAST = 1'b0,
    LS_LAST = 1'b1
  } owner_t;

  owner_t            last_owner;
  logic              rd_pend;
  logic              rd_owner_ls;
  logic              rd_oor;
  logic              err_pend;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  logic              if_win;
  logic              ls_win;
  logic              win_in_range;
  logic [DATA_W-1:0] resp;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
  endfunction

  // Grants are suppressed while reset is high so a store presented then never reaches memory.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (!reset) begin
`ifdef IMEM_ARB_LS_PRIORITY_EN
      ls_win = ls_req;
      if_win = if_req && !ls_req;
`else
      if (if_req && ls_req) begin
        if_win = (last_owner == LS_LAST);
        ls_win = (last_owner == IF_LAST);
      end else begin
        if_win = if_req;
        ls_win = ls_req;
      end
`endif
    end
  end

  always_comb begin
    win_in_range = ls_win ? in_range(ls_addr) : in_range(if_addr);
    mem_en       = (if_win || ls_win) && win_in_range;
    mem_we       = ls_win && ls_we && win_in_range;
    mem_addr     = ls_win ? ls_addr : (if_win ? if_addr : '0);
    mem_wdata    = ls_win ? ls_wdata : '0;
  end

  assign if_gnt = if_win;
  assign ls_gnt = ls_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner  <= LS_LAST;
      rd_pend     <= 1'b0;
      rd_owner_ls <= 1'b0;
      rd_oor      <= 1'b0;
      err_pend    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if (if_win)
        last_owner <= IF_LAST;
      else if (ls_win)
        last_owner <= LS_LAST;
      else
        last_owner <= last_owner;
      rd_pend     <= if_win || (ls_win && !ls_we);
      rd_owner_ls <= ls_win;
      rd_oor      <= !win_in_range;
      err_pend    <= ls_win && !win_in_range;
      if (if_rvalid)
        if_rdata_q <= resp;
      if (ls_rvalid)
        ls_rdata_q <= resp;
    end
  end

  // Memory data arrives the cycle after the grant, so the response is a live mux of
  // mem_rdata backed by a holding register that keeps the last delivered word.
  always_comb begin
    resp      = rd_oor ? '0 : mem_rdata;
    if_rvalid = !reset && rd_pend && !rd_owner_ls;
    ls_rvalid = !reset && rd_pend && rd_owner_ls;
    ls_err    = !reset && err_pend;
    if_rdata  = reset ? '0 : (if_rvalid ? resp : if_rdata_q);
    ls_rdata  = reset ? '0 : (ls_rvalid ? resp : ls_rdata_q);
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: vector table plus tie-stream sequence, responses checked through a queue.
// Honours IMEM_ARB_LS_PRIORITY_EN for the tie expectations.
module tb_imem_arbiter;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 41;
`ifdef IMEM_ARB_LS_PRIORITY_EN
  localparam logic LSP = 1'b1;
`else
  localparam logic LSP = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          ls_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          preload;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory array attached to the DUT
  logic [DW-1:0] ram [0:63];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= DW'(i + 100);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic          rst;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          lreq;
    logic          lwe;
    logic [AW-1:0] laddr;
    logic [DW-1:0] lwdata;
    logic          eig;
    logic          elg;
    logic          een;
    logic          ewe;
  } vec_t;

  typedef struct {
    logic          ls;
    logic          rv;
    logic          err;
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  resp_t         sbq[$];
  vec_t          tbl [0:23];
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] last_if;
  logic [DW-1:0] last_ls;
  logic          m_last;
  int            cyc;
  int            n_cmp;
  int            n_bad;

  function automatic vec_t mk(input logic rst, input logic ireq, input int iaddr,
                              input logic lreq, input logic lwe, input int laddr,
                              input logic [DW-1:0] lwdata, input logic eig,
                              input logic elg, input logic een, input logic ewe);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = AW'(iaddr);
    v.lreq = lreq; v.lwe = lwe; v.laddr = AW'(laddr); v.lwdata = lwdata;
    v.eig = eig; v.elg = elg; v.een = een; v.ewe = ewe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cyc %0d %s: got %h want %h", cyc, nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    resp_t r;
    logic  have;
    logic  e_irv, e_lrv, e_err;
    resp_t p;
    @(negedge clk);
    reset    = v.rst;
    if_req   = v.ireq;
    if_addr  = v.iaddr;
    ls_req   = v.lreq;
    ls_we    = v.lwe;
    ls_addr  = v.laddr;
    ls_wdata = v.lwdata;
    #1;
    cyc++;
    have = 1'b0;
    r = '{ls: 1'b0, rv: 1'b0, err: 1'b0, data: '0, due: 0};
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      r    = sbq.pop_front();
      have = !v.rst;
    end
    e_irv = have && r.rv && !r.ls;
    e_lrv = have && r.rv && r.ls;
    e_err = have && r.err;
    if (e_irv) last_if = r.data;
    if (e_lrv) last_ls = r.data;

    chk("if_gnt", 32'(if_gnt), 32'(v.eig));
    chk("ls_gnt", 32'(ls_gnt), 32'(v.elg));
    chk("mem_en", 32'(mem_en), 32'(v.een));
    chk("mem_we", 32'(mem_we), 32'(v.ewe));
    if (v.een) chk("mem_addr", 32'(mem_addr), 32'(v.eig ? v.iaddr : v.laddr));
    if (v.ewe) chk("mem_wdata", mem_wdata, v.lwdata);
    chk("if_rvalid", 32'(if_rvalid), 32'(e_irv));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(e_lrv));
    chk("ls_err", 32'(ls_err), 32'(e_err));
    chk("if_rdata", if_rdata, v.rst ? '0 : last_if);
    chk("ls_rdata", ls_rdata, v.rst ? '0 : last_ls);

    if (v.rst) begin
      sbq.delete();
      last_if = '0;
      last_ls = '0;
      m_last  = 1'b1;
    end else begin
      if (v.eig) begin
        m_last = 1'b0;
        p = '{ls: 1'b0, rv: 1'b1, err: 1'b0,
              data: (int'(v.iaddr) < DEPTH) ? ref_mem[v.iaddr] : '0, due: cyc + 1};
        sbq.push_back(p);
      end else if (v.elg) begin
        m_last = 1'b1;
        if (!v.lwe) begin
          p = '{ls: 1'b1, rv: 1'b1, err: (int'(v.laddr) >= DEPTH),
                data: (int'(v.laddr) < DEPTH) ? ref_mem[v.laddr] : '0, due: cyc + 1};
          sbq.push_back(p);
        end else if (int'(v.laddr) < DEPTH) begin
          ref_mem[v.laddr] = v.lwdata;
        end else begin
          p = '{ls: 1'b1, rv: 1'b0, err: 1'b1, data: '0, due: cyc + 1};
          sbq.push_back(p);
        end
      end
    end
  endtask

  initial begin
    vec_t v;
    n_cmp = 0; n_bad = 0; cyc = 0;
    last_if = '0; last_ls = '0; m_last = 1'b1;
    reset = 1'b1; preload = 1'b1;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = DW'(i + 100);

    //           rst ireq ia lreq lwe la  lwdata        eig   elg  een  ewe
    tbl[0]  = mk(1, 1, 0,  1, 0, 1,  32'h0,        0,    0,   0, 0);
    tbl[1]  = mk(1, 1, 0,  1, 0, 1,  32'h0,        0,    0,   0, 0);
    tbl[2]  = mk(0, 1, 0,  1, 0, 1,  32'h0,        !LSP, LSP, 1, 0);
    tbl[3]  = mk(0, 1, 2,  1, 0, 3,  32'h0,        0,    1,   1, 0);
    tbl[4]  = mk(0, 1, 4,  1, 0, 6,  32'h0,        !LSP, LSP, 1, 0);
    tbl[5]  = mk(0, 1, 7,  1, 0, 8,  32'h0,        0,    1,   1, 0);
    tbl[6]  = mk(0, 1, 0,  0, 0, 0,  32'h0,        1,    0,   1, 0);
    tbl[7]  = mk(0, 1, 1,  0, 0, 0,  32'h0,        1,    0,   1, 0);
    tbl[8]  = mk(0, 1, 2,  0, 0, 0,  32'h0,        1,    0,   1, 0);
    tbl[9]  = mk(0, 1, 3,  0, 0, 0,  32'h0,        1,    0,   1, 0);
    tbl[10] = mk(0, 0, 0,  1, 1, 5,  32'hDEADBEEF, 0,    1,   1, 1);
    tbl[11] = mk(0, 0, 0,  1, 0, 5,  32'h0,        0,    1,   1, 0);
    tbl[12] = mk(0, 0, 0,  0, 0, 0,  32'h0,        0,    0,   0, 0);
    tbl[13] = mk(0, 0, 0,  1, 0, 50, 32'h0,        0,    1,   0, 0);
    tbl[14] = mk(0, 1, 63, 0, 0, 0,  32'h0,        1,    0,   0, 0);
    tbl[15] = mk(0, 0, 0,  0, 0, 0,  32'h0,        0,    0,   0, 0);
    tbl[16] = mk(0, 0, 0,  1, 1, 45, 32'h12345678, 0,    1,   0, 0);
    tbl[17] = mk(0, 0, 0,  0, 0, 0,  32'h0,        0,    0,   0, 0);
    tbl[18] = mk(0, 0, 0,  1, 0, 2,  32'h0,        0,    1,   1, 0);
    tbl[19] = mk(1, 1, 9,  1, 1, 7,  32'hCAFEF00D, 0,    0,   0, 0);
    tbl[20] = mk(0, 0, 0,  0, 0, 0,  32'h0,        0,    0,   0, 0);
    tbl[21] = mk(0, 1, 10, 1, 0, 11, 32'h0,        !LSP, LSP, 1, 0);
    tbl[22] = mk(0, 0, 0,  1, 0, 7,  32'h0,        0,    1,   1, 0);
    tbl[23] = mk(0, 0, 0,  0, 0, 0,  32'h0,        0,    0,   0, 0);

    @(negedge clk);
    preload = 1'b0;

    for (int i = 0; i < 24; i++) step(tbl[i]);

    // Sustained ties: winner follows the bench's own last-owner model
    for (int i = 0; i < 6; i++) begin
      logic eig;
      eig = LSP ? 1'b0 : m_last;
      v = mk(0, 1, 12 + i, 1, 0, 20 + i, 32'h0, eig, !eig, 1, 0);
      step(v);
    end
    step(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    chk("drain", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
